// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, memory address issue, 1-cycle return
// alignment with stall hold, redirect bubble insertion and unmapped-fetch flagging.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_next,
   input  logic        redirect,
   input  logic        stall,
   input  logic [31:0] inst_raw,
   output logic [31:0] fetch_addr,
   output logic        imem_en,
   output logic        bios_en,
   output logic [31:0] pc_plus4,
   output logic        inst_sel_imem,
   output logic [31:0] pc_f,
   output logic [31:0] inst_out,
   output logic        inst_valid,
   output logic        fetch_err
);

   logic [31:0] pc_req_reg;
   logic [31:0] pc_f_reg;
   logic [31:0] hold_inst_reg;
   logic        valid_f_reg;
   logic        mapped_f_reg;
   logic        hold_valid_reg;
   logic        fetch_err_reg;

   logic [31:0] pc_next_aligned;
   logic        req_mapped;

   assign pc_next_aligned = pc_next & ~32'd3;
   assign req_mapped      = (pc_req_reg[31:28] == 4'b0001) || (pc_req_reg[31:28] == 4'b0100);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_req_reg     <= RESET_PC;
         pc_f_reg       <= RESET_PC;
         valid_f_reg    <= 1'b0;
         mapped_f_reg   <= 1'b0;
         hold_valid_reg <= 1'b0;
         hold_inst_reg  <= NOP_INST;
         fetch_err_reg  <= 1'b0;
      end else if (redirect) begin
         // The in-flight fetch is killed; pc_f keeps its stale value under valid_f=0.
         pc_req_reg     <= pc_next_aligned;
         valid_f_reg    <= 1'b0;
         hold_valid_reg <= 1'b0;
      end else if (stall) begin
         if (!hold_valid_reg) begin
            hold_inst_reg  <= inst_raw;
            hold_valid_reg <= 1'b1;
         end
      end else begin
         pc_req_reg     <= pc_next_aligned;
         pc_f_reg       <= pc_req_reg;
         valid_f_reg    <= 1'b1;
         mapped_f_reg   <= req_mapped;
         hold_valid_reg <= 1'b0;
         if (!req_mapped)
            fetch_err_reg <= 1'b1;
      end
   end

   // Outputs are forced to their reset values while rst is asserted, before the edge lands.
   assign fetch_addr    = rst ? pc_req_reg : RESET_PC;
   assign imem_en       = (fetch_addr[31:28] == 4'b0001);
   assign bios_en       = (fetch_addr[31:28] == 4'b0100);
   assign pc_plus4      = fetch_addr + 32'd4;
   assign pc_f          = pc_f_reg;
   assign inst_sel_imem = ~pc_f_reg[30];
   assign inst_valid    = rst & valid_f_reg & mapped_f_reg;
   assign inst_out      = !inst_valid   ? NOP_INST      :
                          hold_valid_reg ? hold_inst_reg : inst_raw;
   assign fetch_err     = fetch_err_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the memory returns word = address for mapped regions.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_next;
   logic        redirect;
   logic        stall;
   logic [31:0] inst_raw;
   logic [31:0] fetch_addr;
   logic        imem_en;
   logic        bios_en;
   logic [31:0] pc_plus4;
   logic        inst_sel_imem;
   logic [31:0] pc_f;
   logic [31:0] inst_out;
   logic        inst_valid;
   logic        fetch_err;

   logic        use_loop;
   logic [31:0] pc_next_ovr;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign pc_next = use_loop ? pc_plus4 : pc_next_ovr;

   // Synchronous-read memory with one cycle of latency.
   always @(posedge clk) begin
      if (imem_en || bios_en)
         inst_raw <= fetch_addr;
      else
         inst_raw <= 32'hDEAD_BEEF;
   end

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .pc_next      (pc_next),
      .redirect     (redirect),
      .stall        (stall),
      .inst_raw     (inst_raw),
      .fetch_addr   (fetch_addr),
      .imem_en      (imem_en),
      .bios_en      (bios_en),
      .pc_plus4     (pc_plus4),
      .inst_sel_imem(inst_sel_imem),
      .pc_f         (pc_f),
      .inst_out     (inst_out),
      .inst_valid   (inst_valid),
      .fetch_err    (fetch_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0;
      use_loop = 1'b1; pc_next_ovr = 32'h0;

      // Reset held for two edges
      step; step;
      chk("rst_fetch_addr", fetch_addr, 32'h4000_0000);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst_out", inst_out, NOP);
      chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
      chk("rst_pc_plus4", pc_plus4, 32'h4000_0004);
      chk("rst_bios_en", {30'b0, imem_en, bios_en}, 32'd1);
      $display("reset: fetch_addr=%h inst_valid=%b", fetch_addr, inst_valid);

      // Release: sequential BIOS fetch
      rst = 1'b1;
      step;
      chk("rel1_fetch_addr", fetch_addr, 32'h4000_0004);
      chk("rel1_inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("rel1_pc_f", pc_f, 32'h4000_0000);
      chk("rel1_inst_out", inst_out, 32'h4000_0000);
      $display("release: pc_f=%h inst_out=%h", pc_f, inst_out);
      step;
      chk("rel2_inst_out", inst_out, 32'h4000_0004);
      step;
      chk("rel3_pc_f", pc_f, 32'h4000_0008);
      chk("rel3_fetch_addr", fetch_addr, 32'h4000_000C);

      // Stall for three edges
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("stall_inst_out", inst_out, 32'h4000_0008);
         chk("stall_fetch_addr", fetch_addr, 32'h4000_000C);
         chk("stall_pc_f", pc_f, 32'h4000_0008);
         chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
         $display("stall %0d: pc_f=%h inst_out=%h", i, pc_f, inst_out);
      end
      stall = 1'b0;
      step;
      chk("unstall_pc_f", pc_f, 32'h4000_000C);
      chk("unstall_inst_out", inst_out, 32'h4000_000C);
      chk("unstall_fetch_addr", fetch_addr, 32'h4000_0010);

      // Redirect into IMEM
      redirect = 1'b1; use_loop = 1'b0; pc_next_ovr = 32'h1000_0100;
      step;
      redirect = 1'b0; use_loop = 1'b1;
      chk("redir_inst_out", inst_out, NOP);
      chk("redir_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("redir_fetch_addr", fetch_addr, 32'h1000_0100);
      chk("redir_imem_en", {30'b0, imem_en, bios_en}, 32'd2);
      $display("redirect bubble: inst_out=%h fetch_addr=%h", inst_out, fetch_addr);
      step;
      chk("redir_tgt_pc_f", pc_f, 32'h1000_0100);
      chk("redir_tgt_sel_imem", {31'b0, inst_sel_imem}, 32'd1);
      chk("redir_tgt_inst_out", inst_out, 32'h1000_0100);
      chk("redir_tgt_fetch_addr", fetch_addr, 32'h1000_0104);

      // Stall to arm the hold register, then redirect while still stalling
      stall = 1'b1;
      step;
      chk("hold_inst_out", inst_out, 32'h1000_0100);
      redirect = 1'b1; use_loop = 1'b0; pc_next_ovr = 32'h4000_0200;
      step;
      redirect = 1'b0; stall = 1'b0; use_loop = 1'b1;
      chk("rds_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rds_inst_out", inst_out, NOP);
      chk("rds_fetch_addr", fetch_addr, 32'h4000_0200);
      step;
      chk("rds_tgt_pc_f", pc_f, 32'h4000_0200);
      chk("rds_tgt_inst_out", inst_out, 32'h4000_0200);
      chk("rds_tgt_sel_imem", {31'b0, inst_sel_imem}, 32'd0);
      $display("redirect during stall: pc_f=%h inst_out=%h", pc_f, inst_out);

      // Misaligned, unmapped target
      use_loop = 1'b0; pc_next_ovr = 32'h2000_0003;
      step;
      use_loop = 1'b1;
      chk("unm_fetch_addr", fetch_addr, 32'h2000_0000);
      chk("unm_en", {30'b0, imem_en, bios_en}, 32'd0);
      chk("unm_err_before", {31'b0, fetch_err}, 32'd0);
      step;
      chk("unm_inst_out", inst_out, NOP);
      chk("unm_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("unm_fetch_err", {31'b0, fetch_err}, 32'd1);
      chk("unm_pc_f", pc_f, 32'h2000_0000);
      $display("unmapped: pc_f=%h fetch_err=%b", pc_f, fetch_err);

      // Wrap of pc_plus4
      use_loop = 1'b0; pc_next_ovr = 32'hFFFF_FFFC;
      step;
      chk("wrap_fetch_addr", fetch_addr, 32'hFFFF_FFFC);
      chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
      chk("err_sticky", {31'b0, fetch_err}, 32'd1);
      $display("wrap: fetch_addr=%h pc_plus4=%h", fetch_addr, pc_plus4);

      // Reset mid-operation clears sticky error
      pc_next_ovr = 32'h4000_0000; rst = 1'b0;
      step;
      chk("rst2_fetch_err", {31'b0, fetch_err}, 32'd0);
      chk("rst2_fetch_addr", fetch_addr, 32'h4000_0000);
      chk("rst2_inst_valid", {31'b0, inst_valid}, 32'd0);
      $display("reset again: fetch_err=%b fetch_addr=%h", fetch_err, fetch_addr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register and instruction-fetch front end of the 3-stage RISC-V core.
- Issues the fetch address to the BIOS and IMEM synchronous-read memories, which have 1-cycle read latency.
- Returns the fetched instruction and its PC to decode, with stall hold, redirect bubble insertion and unmapped-fetch detection.
- Sits between the PC select mux, whose next-PC output it registers, and the IMEM/BIOS instruction-read mux, whose output it consumes.

Parameters:
RESET_PC, 32'h4000_0000, PC after reset (BIOS base)
NOP_INST, 32'h0000_0013, instruction injected for bubbles (addi x0,x0,0)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
pc_next  input  32  next PC from PC select mux
redirect  input  1  taken jump/branch resolved this cycle; kill in-flight fetch
stall  input  1  decode cannot accept; hold fetch state
inst_raw  input  32  instruction from IMEM/BIOS read mux (data for address issued previous cycle)
fetch_addr  output  32  address presented to memories this cycle (= pc_req)
imem_en  output  1  fetch_addr in IMEM region (fetch_addr[31:28]==4'b0001)
bios_en  output  1  fetch_addr in BIOS region (fetch_addr[31:28]==4'b0100)
pc_plus4  output  32  pc_req + 4, to PC select mux
inst_sel_imem  output  1  pc_f[30]==0 and valid region IMEM; select for instruction-read mux (1 = IMEM)
pc_f  output  32  PC of instruction on inst_out
inst_out  output  32  instruction to decode
inst_valid  output  1  inst_out is a real fetched instruction
fetch_err  output  1  sticky: an unmapped address was fetched

Behaviour:
- State: pc_req[31:0], pc_f[31:0], valid_f, mapped_f, hold_valid, hold_inst[31:0], fetch_err.
- Reset (rst==0 at edge): pc_req=RESET_PC, pc_f=RESET_PC, valid_f=0, mapped_f=0, hold_valid=0, hold_inst=NOP_INST, fetch_err=0.
  - During reset cycle outputs: fetch_addr=RESET_PC, inst_out=NOP_INST, inst_valid=0.
  - Reset mid-operation discards all in-flight and held instructions.
- fetch_addr = pc_req (combinational). pc_plus4 = pc_req+32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Address capture: pc_req captures {pc_next[31:2],2'b00}; bits [1:0] are always forced to zero.
- Fetch-return latency is 1 cycle. The address issued in cycle t appears on inst_out in cycle t+1 with pc_f = that address.
- Priority per edge: reset > redirect > stall > normal.
- Normal (no stall, no redirect):
  - pc_req<=pc_next.
  - pc_f<=pc_req, valid_f<=1, mapped_f<=imem_en|bios_en.
  - hold_valid<=0.
- Stall (redirect=0):
  - pc_req, pc_f, valid_f, mapped_f unchanged.
  - On the first stall cycle (hold_valid==0): hold_inst<=inst_raw, hold_valid<=1.
  - While hold_valid==1: hold_inst unchanged. This covers memory re-reading pc_req, i.e. the following instruction.
  - On the first non-stall edge, hold_valid<=0.
- Redirect (regardless of stall):
  - pc_req<=pc_next, valid_f<=0, hold_valid<=0.
  - Exactly one bubble reaches decode; the target instruction appears 1 cycle after the redirect edge.
- Output select:
  - inst_out = !valid_f ? NOP_INST : !mapped_f ? NOP_INST : hold_valid ? hold_inst : inst_raw.
  - inst_valid = valid_f & mapped_f.
- inst_sel_imem = ~pc_f[30], registered alongside pc_f so the mux selects with the returning address, not the current one.
- Unmapped fetch: fetch_err<=1 on the edge where valid_f becomes 1 with mapped_f 0. It is sticky until reset. The fetch does not halt; decode sees NOP with inst_valid=0.
- Redirect and stall held high together: redirect wins each cycle; stall is re-evaluated afterwards.

Test Plan:
- Reset release:
  - Stimulus: rst 0 for 2 cycles, then 1; pc_next=pc_plus4 looped back; BIOS returns word=addr.
  - Response: fetch_addr 4000_0000, 4000_0004, 4000_0008…; inst_valid first 1 one cycle after release with pc_f=4000_0000, inst_out=4000_0000.
- Stall hold:
  - Stimulus: stall=1 for 3 cycles while pc_f=4000_0008.
  - Response: inst_out stays 4000_0008, fetch_addr stays 4000_000C, inst_valid=1 throughout; after release next inst pc_f=4000_000C.
- Redirect:
  - Stimulus: redirect=1, pc_next=1000_0100 at pc_req=4000_0010.
  - Response: next cycle inst_out=0000_0013, inst_valid=0, fetch_addr=1000_0100; following cycle pc_f=1000_0100, inst_sel_imem=1.
- Redirect during stall:
  - Stimulus: stall=1 and redirect=1 together, pc_next=4000_0200.
  - Response: hold cleared, one bubble, then pc_f=4000_0200.
- Misaligned/unmapped target:
  - Stimulus: pc_next=2000_0003.
  - Response: fetch_addr=2000_0000, imem_en=bios_en=0; next cycle inst_out=NOP, inst_valid=0, fetch_err=1, and fetch_err stays 1 until rst=0.
- Wrap:
  - Stimulus: pc_req=FFFF_FFFC.
  - Response: pc_plus4=0000_0000.
